serial_adder: RTL and testbench

- Bit-serial adder: the additive counterpart to the team's combinational full subtractor.
- Accepts two WIDTH-bit operands plus a carry-in over a valid/ready handshake.
- Computes the sum LSB-first through a single 1-bit full-adder cell, one bit per clock.
- Presents sum and carry-out over a second valid/ready handshake. Used where area matters more than latency.

---
 rtl/serial_adder_pkg.sv | 17 +
 rtl/full_adder.sv | 13 +
 rtl/serial_adder.sv | 122 ++++++++++++
 tb/tb_serial_adder.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned SERIAL_ADDER_DEFAULT_WIDTH = 8;

    // Bit-counter width; at least one bit so WIDTH=1 still has a counter.
    function automatic int unsigned cnt_width(input int w);
        return (w > 1) ? int'($clog2(w)) : 1;
    endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit combinational full adder: the one arithmetic cell of serial_adder.
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic sum_o,
    output logic carry_o
);

    assign sum_o   = a_i ^ b_i ^ c_i;
    assign carry_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: LSB-first, one bit per clock, valid/ready on both sides.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf_o.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = SERIAL_ADDER_DEFAULT_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             c_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o
`ifdef SERIAL_ADDER_OVF_EN
   ,output logic             ovf_o
`endif
);

    localparam int unsigned     CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             fa_sum, fa_co;
    logic             last_bit;

    full_adder u_full_adder (
        .a_i     (a_q[0]),
        .b_i     (b_q[0]),
        .c_i     (carry_q),
        .sum_o   (fa_sum),
        .carry_o (fa_co)
    );

    assign last_bit = (state_q == RUN) && (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        unique case (state_q)
            IDLE: begin
                if (valid_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    carry_d = c_i;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // New sum bit enters at the MSB; after WIDTH shifts bit 0 is the LSB.
                sum_d   = (sum_q >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = fa_co;
                if (last_bit) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_q;

    // Signed overflow: carry into the MSB differs from carry out of it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ovf_q <= 1'b0;
        end else if (last_bit) begin
            ovf_q <= carry_q ^ fa_co;
        end
    end

    assign ovf_o = ovf_q;
`else
    // Overflow tracking not built.
`endif

    assign ready_o = (state_q == IDLE);
    assign valid_o = (state_q == DONE);
    assign sum_o   = sum_q;
    assign carry_o = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=8 and WIDTH=1) and its full_adder cell.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       d8_valid = 1'b0, d8_ready_o, d8_c = 1'b0, d8_valid_o, d8_ready = 1'b0;
    logic [7:0] d8_a = '0, d8_b = '0, d8_sum;
    logic       d8_carry, d8_ovf;

    logic       d1_valid = 1'b0, d1_ready_o, d1_c = 1'b0, d1_valid_o, d1_ready = 1'b0;
    logic [0:0] d1_a = '0, d1_b = '0, d1_sum;
    logic       d1_carry, d1_ovf;

    logic       fa_a = 1'b0, fa_b = 1'b0, fa_c = 1'b0, fa_s, fa_co;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk_i   (clk),
        .rst_i   (rst),
        .valid_i (d8_valid),
        .ready_o (d8_ready_o),
        .a_i     (d8_a),
        .b_i     (d8_b),
        .c_i     (d8_c),
        .valid_o (d8_valid_o),
        .ready_i (d8_ready),
        .sum_o   (d8_sum),
        .carry_o (d8_carry)
`ifdef SERIAL_ADDER_OVF_EN
       ,.ovf_o   (d8_ovf)
`endif
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk_i   (clk),
        .rst_i   (rst),
        .valid_i (d1_valid),
        .ready_o (d1_ready_o),
        .a_i     (d1_a),
        .b_i     (d1_b),
        .c_i     (d1_c),
        .valid_o (d1_valid_o),
        .ready_i (d1_ready),
        .sum_o   (d1_sum),
        .carry_o (d1_carry)
`ifdef SERIAL_ADDER_OVF_EN
       ,.ovf_o   (d1_ovf)
`endif
    );

    full_adder u_fa (
        .a_i     (fa_a),
        .b_i     (fa_b),
        .c_i     (fa_c),
        .sum_o   (fa_s),
        .carry_o (fa_co)
    );

`ifndef SERIAL_ADDER_OVF_EN
    assign d8_ovf = 1'b0;
    assign d1_ovf = 1'b0;
`endif

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
        logic [7:0] sum;
        logic       carry;
        logic       ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands to dut8, return cycles from acceptance edge to valid_o (20 = timeout).
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c, output int lat);
        int n;
        n = 0;
        while (!d8_ready_o && n < 20) begin
            tick();
            n++;
        end
        check("ready_before_op8", 64'(d8_ready_o), 64'd1);
        d8_a = a;
        d8_b = b;
        d8_c = c;
        d8_valid = 1'b1;
        tick();
        d8_valid = 1'b0;
        n = 0;
        while (!d8_valid_o && n < 20) begin
            tick();
            n++;
        end
        lat = n;
    endtask

    task automatic release8();
        d8_ready = 1'b1;
        tick();
        d8_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int n;

        vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[5] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};
        vecs[6] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[7] = '{8'h3C, 8'hC3, 1'b0, 8'hFF, 1'b0, 1'b0};

        // Reset state, observed without any clock edge.
        #2;
        check("rst_ready", 64'(d8_ready_o), 64'd1);
        check("rst_valid", 64'(d8_valid_o), 64'd0);
        check("rst_sum", 64'(d8_sum), 64'd0);
        check("rst_carry", 64'(d8_carry), 64'd0);
        check("rst_ovf", 64'(d8_ovf), 64'd0);

        // Full-adder cell, all 8 input combinations.
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            logic [1:0] exp;
            v = 3'(i);
            fa_a = v[2];
            fa_b = v[1];
            fa_c = v[0];
            exp = 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
            #1;
            check("fa_sum", 64'(fa_s), 64'(exp[0]));
            check("fa_carry", 64'(fa_co), 64'(exp[1]));
        end

        @(negedge clk);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            op8(vecs[i].a, vecs[i].b, vecs[i].c, lat);
            check("vec_latency", 64'(lat), 64'd8);
            check("vec_sum", 64'(d8_sum), 64'(vecs[i].sum));
            check("vec_carry", 64'(d8_carry), 64'(vecs[i].carry));
`ifdef SERIAL_ADDER_OVF_EN
            check("vec_ovf", 64'(d8_ovf), 64'(vecs[i].ovf));
`endif
            release8();
            check("vec_back_idle", 64'(d8_ready_o), 64'd1);
        end

        // Backpressure: result held stable in DONE.
        op8(8'h21, 8'h10, 1'b1, lat);
        for (int k = 0; k < 5; k++) begin
            check("bp_valid", 64'(d8_valid_o), 64'd1);
            check("bp_sum", 64'(d8_sum), 64'h32);
            check("bp_carry", 64'(d8_carry), 64'd0);
            tick();
        end
        release8();

        // valid_i pulsed with new operands during RUN is ignored.
        d8_a = 8'h01;
        d8_b = 8'h02;
        d8_c = 1'b0;
        d8_valid = 1'b1;
        tick();
        d8_valid = 1'b0;
        tick();
        d8_valid = 1'b1;
        d8_a = 8'h55;
        d8_b = 8'h55;
        d8_c = 1'b1;
        tick();
        check("run_ready_low", 64'(d8_ready_o), 64'd0);
        tick();
        d8_valid = 1'b0;
        n = 0;
        while (!d8_valid_o && n < 20) begin
            tick();
            n++;
        end
        check("ign_sum", 64'(d8_sum), 64'h03);
        check("ign_carry", 64'(d8_carry), 64'd0);
        release8();

        // Asynchronous reset on the 3rd RUN cycle.
        d8_a = 8'hF0;
        d8_b = 8'h0F;
        d8_c = 1'b1;
        d8_valid = 1'b1;
        tick();
        d8_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("mid_rst_ready", 64'(d8_ready_o), 64'd1);
        check("mid_rst_valid", 64'(d8_valid_o), 64'd0);
        check("mid_rst_sum", 64'(d8_sum), 64'd0);
        check("mid_rst_carry", 64'(d8_carry), 64'd0);
        tick();
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("post_rst_no_valid", 64'(d8_valid_o), 64'd0);
        end

        op8(8'h12, 8'h34, 1'b0, lat);
        check("after_rst_latency", 64'(lat), 64'd8);
        check("after_rst_sum", 64'(d8_sum), 64'h46);
        check("after_rst_carry", 64'(d8_carry), 64'd0);
        release8();

        // WIDTH=1: a single RUN cycle.
        d1_a = 1'b1;
        d1_b = 1'b1;
        d1_c = 1'b1;
        d1_valid = 1'b1;
        tick();
        d1_valid = 1'b0;
        check("w1_ready_low", 64'(d1_ready_o), 64'd0);
        tick();
        check("w1_valid", 64'(d1_valid_o), 64'd1);
        check("w1_sum", 64'(d1_sum), 64'd1);
        check("w1_carry", 64'(d1_carry), 64'd1);
        d1_ready = 1'b1;
        tick();
        d1_ready = 1'b0;
        check("w1_idle", 64'(d1_ready_o), 64'd1);

        d1_a = 1'b0;
        d1_b = 1'b1;
        d1_c = 1'b0;
        d1_valid = 1'b1;
        tick();
        d1_valid = 1'b0;
        tick();
        check("w1b_valid", 64'(d1_valid_o), 64'd1);
        check("w1b_sum", 64'(d1_sum), 64'd1);
        check("w1b_carry", 64'(d1_carry), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
